// File: rtl/tomasulo_cdb_sched.sv
// Tomasulo common-data-bus scheduler: reserves a CDB slot at issue time through a
// latency-indexed reservation shift register, then registers the result broadcast.
module tomasulo_cdb_sched #(
  parameter int M  = 4,
  parameter int D  = 8,
  parameter int W  = 32,
  parameter int TW = 5,
  localparam int LW = $clog2(D + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [M-1:0]    req,
  input  logic [M*LW-1:0] lat,
  output logic [M-1:0]    gnt,
  output logic [D:0]      sch_r,
  input  logic [M-1:0]    res_vld,
  input  logic [M*TW-1:0] res_tag,
  input  logic [M*W-1:0]  res_wdata,
  output logic            cdb_vld_r,
  output logic [TW-1:0]   cdb_tag_r,
  output logic [W-1:0]    cdb_wdata_r,
  output logic            err_r
);

  localparam int PW = (M > 1) ? $clog2(M) : 1;

  logic [PW-1:0] ptr_r;
  logic [M-1:0]  legal_s;
  logic [M-1:0]  elig_s;
  logic          found_s;
  logic [PW-1:0] gidx_s;
  logic [LW-1:0] glat_s;
  logic [D:0]    sch_nxt_s;
  logic [TW-1:0] sel_tag_s;
  logic [W-1:0]  sel_data_s;
  logic          ill_s;
  logic          multi_s;
  logic          miss_s;

  // Eligibility: legal latency and the target slot not already booked.
  always_comb begin
    legal_s = '0;
    elig_s  = '0;
    for (int i = 0; i < M; i++) begin
      if ((lat[i*LW +: LW] != '0) && (int'(lat[i*LW +: LW]) <= D)) begin
        legal_s[i] = 1'b1;
        elig_s[i]  = req[i] & ~sch_r[lat[i*LW +: LW]];
      end else begin
        legal_s[i] = 1'b0;
        elig_s[i]  = 1'b0;
      end
    end
  end

  // Round-robin pick starting just after the last winner.
  always_comb begin
    found_s = 1'b0;
    gidx_s  = ptr_r;
    for (int o = 1; o <= M; o++) begin
      if (!found_s && elig_s[(int'(ptr_r) + o) % M]) begin
        found_s = 1'b1;
        gidx_s  = PW'((int'(ptr_r) + o) % M);
      end else begin
        found_s = found_s;
      end
    end
    found_s = found_s & ~rst;
    glat_s  = lat[int'(gidx_s)*LW +: LW];
    gnt     = '0;
    if (found_s) begin
      gnt[gidx_s] = 1'b1;
    end else begin
      gnt = '0;
    end
  end

  // Reservation vector shifts toward slot 0; a grant books slot L-1 of the next cycle.
  always_comb begin
    sch_nxt_s = '0;
    for (int k = 0; k < D; k++) begin
      sch_nxt_s[k] = sch_r[k+1] | (found_s && (glat_s == LW'(k + 1)));
    end
    sch_nxt_s[D] = 1'b0;
  end

  // Lowest-index valid unit drives the bus, even on a collision.
  always_comb begin
    sel_tag_s  = '0;
    sel_data_s = '0;
    for (int i = M - 1; i >= 0; i--) begin
      if (res_vld[i]) begin
        sel_tag_s  = res_tag[i*TW +: TW];
        sel_data_s = res_wdata[i*W +: W];
      end else begin
        sel_tag_s  = sel_tag_s;
        sel_data_s = sel_data_s;
      end
    end
  end

  // Protocol violations: illegal latency, multiple results, result/booking disagreement.
  always_comb begin
    ill_s   = |(req & ~legal_s);
    multi_s = |(res_vld & (res_vld - M'(1)));
    miss_s  = (|res_vld) != sch_r[0];
  end

  // State and broadcast registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sch_r       <= '0;
      ptr_r       <= PW'(M - 1);
      cdb_vld_r   <= 1'b0;
      cdb_tag_r   <= '0;
      cdb_wdata_r <= '0;
      err_r       <= 1'b0;
    end else begin
      sch_r     <= sch_nxt_s;
      cdb_vld_r <= |res_vld;
      err_r     <= err_r | ill_s | multi_s | miss_s;
      if (found_s) begin
        ptr_r <= gidx_s;
      end else begin
        ptr_r <= ptr_r;
      end
      if (|res_vld) begin
        cdb_tag_r   <= sel_tag_s;
        cdb_wdata_r <= sel_data_s;
      end else begin
        cdb_tag_r   <= cdb_tag_r;
        cdb_wdata_r <= cdb_wdata_r;
      end
    end
  end

endmodule

// File: tb/tb_tomasulo_cdb_sched.sv
// Directed bench for tomasulo_cdb_sched: each task drives one scenario and checks
// grants, reservation vector, CDB broadcast and the sticky error flag.
module tb_tomasulo_cdb_sched;
  localparam int M  = 4;
  localparam int D  = 8;
  localparam int W  = 32;
  localparam int TW = 5;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [M-1:0]    req;
  logic [M*LW-1:0] lat;
  logic [M-1:0]    gnt;
  logic [D:0]      sch_r;
  logic [M-1:0]    res_vld;
  logic [M*TW-1:0] res_tag;
  logic [M*W-1:0]  res_wdata;
  logic            cdb_vld_r;
  logic [TW-1:0]   cdb_tag_r;
  logic [W-1:0]    cdb_wdata_r;
  logic            err_r;

  int checks = 0;
  int errors = 0;

  tomasulo_cdb_sched #(.M(M), .D(D), .W(W), .TW(TW)) dut (
    .clk(clk), .rst(rst), .req(req), .lat(lat), .gnt(gnt), .sch_r(sch_r),
    .res_vld(res_vld), .res_tag(res_tag), .res_wdata(res_wdata),
    .cdb_vld_r(cdb_vld_r), .cdb_tag_r(cdb_tag_r), .cdb_wdata_r(cdb_wdata_r),
    .err_r(err_r)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
    lat = {LW'(l3), LW'(l2), LW'(l1), LW'(l0)};
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; res_vld = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0001; set_lat(3, 0, 0, 0); res_vld = '0;
    res_tag = '0; res_wdata = '0;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt got %b exp 0000", gnt); end
    tick();
    tick();
    checks++; if (sch_r !== 9'b0) begin errors++; $display("FAIL rst_sch got %b exp 0", sch_r); end
    checks++; if (cdb_vld_r !== 1'b0) begin errors++; $display("FAIL rst_vld got %b exp 0", cdb_vld_r); end
    checks++; if (cdb_tag_r !== 5'd0) begin errors++; $display("FAIL rst_tag got %0d exp 0", cdb_tag_r); end
    checks++; if (cdb_wdata_r !== 32'd0) begin errors++; $display("FAIL rst_data got %h exp 0", cdb_wdata_r); end
    checks++; if (err_r !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err_r); end
    rst = 1'b0; req = '0;
  endtask

  task automatic test_single();
    req = 4'b0001; set_lat(3, 0, 0, 0);
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b exp 0001", gnt); end
    tick(); req = '0;
    checks++; if (sch_r !== 9'b000000100) begin errors++; $display("FAIL single_sch1 got %b exp 000000100", sch_r); end
    tick();
    checks++; if (sch_r !== 9'b000000010) begin errors++; $display("FAIL single_sch2 got %b exp 000000010", sch_r); end
    tick();
    res_vld = 4'b0001; res_tag = {5'd0, 5'd0, 5'd0, 5'd5}; res_wdata = {96'd0, 32'hDEADBEEF};
    tick(); res_vld = '0;
    checks++; if (cdb_vld_r !== 1'b1) begin errors++; $display("FAIL single_vld got %b exp 1", cdb_vld_r); end
    checks++; if (cdb_tag_r !== 5'd5) begin errors++; $display("FAIL single_tag got %0d exp 5", cdb_tag_r); end
    checks++; if (cdb_wdata_r !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got %h exp deadbeef", cdb_wdata_r); end
    checks++; if (err_r !== 1'b0) begin errors++; $display("FAIL single_err got %b exp 0", err_r); end
    tick();
    checks++; if (cdb_vld_r !== 1'b0) begin errors++; $display("FAIL single_vld_drop got %b exp 0", cdb_vld_r); end
    checks++; if (cdb_tag_r !== 5'd5) begin errors++; $display("FAIL single_tag_hold got %0d exp 5", cdb_tag_r); end
    checks++; if (err_r !== 1'b0) begin errors++; $display("FAIL single_err2 got %b exp 0", err_r); end
  endtask

  task automatic test_back_to_back();
    logic [M-1:0] exp_g;
    do_reset();
    set_lat(2, 2, 2, 2);
    res_tag = {5'd13, 5'd12, 5'd11, 5'd10};
    res_wdata = {32'd3, 32'd2, 32'd1, 32'd0};
    for (int t = 0; t < 7; t++) begin
      req = (t < 4) ? 4'b1111 : 4'b0000;
      res_vld = (t >= 2 && t <= 5) ? M'(1 << (t - 2)) : 4'b0000;
      #1;
      if (t < 4) begin
        exp_g = M'(1 << t);
        checks++; if (gnt !== exp_g) begin errors++; $display("FAIL b2b_gnt t=%0d got %b exp %b", t, gnt, exp_g); end
      end
      if (t >= 1 && t <= 4) begin
        checks++; if (sch_r[1] !== 1'b1) begin errors++; $display("FAIL b2b_sch1 t=%0d got %b exp 1", t, sch_r[1]); end
      end
      if (t >= 3) begin
        checks++;
        if (cdb_vld_r !== 1'b1 || cdb_tag_r !== 5'(10 + t - 3)) begin
          errors++; $display("FAIL b2b_cdb t=%0d got vld %b tag %0d exp vld 1 tag %0d", t, cdb_vld_r, cdb_tag_r, 10 + t - 3);
        end
      end
      tick();
    end
    checks++; if (err_r !== 1'b0) begin errors++; $display("FAIL b2b_err got %b exp 0", err_r); end
  endtask

  task automatic test_slot_conflict();
    res_vld = '0;
    req = 4'b0010; set_lat(0, 4, 0, 0);
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL conf_gnt0 got %b exp 0010", gnt); end
    tick(); req = '0;
    tick(); req = 4'b0001; set_lat(2, 0, 0, 0);
    #1;
    checks++; if (sch_r !== 9'b000000100) begin errors++; $display("FAIL conf_sch2 got %b exp 000000100", sch_r); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL conf_busy got %b exp 0000", gnt); end
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL conf_retry got %b exp 0001", gnt); end
    tick(); req = '0; res_vld = 4'b0010;
    tick(); res_vld = 4'b0001;
    tick(); res_vld = '0;
    req = 4'b0011; set_lat(2, 2, 0, 0);
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL race_gnt got %b exp 0010", gnt); end
    tick(); req = 4'b0001; set_lat(1, 0, 0, 0);
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL race_loser got %b exp 0000", gnt); end
    tick(); req = '0; res_vld = 4'b0010;
    tick(); res_vld = '0;
    checks++; if (cdb_tag_r !== 5'd11) begin errors++; $display("FAIL race_tag got %0d exp 11", cdb_tag_r); end
    checks++; if (err_r !== 1'b0) begin errors++; $display("FAIL conf_err got %b exp 0", err_r); end
  endtask

  task automatic test_collision();
    req = 4'b0100; set_lat(0, 0, 1, 0);
    #1;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL coll_gnt got %b exp 0100", gnt); end
    tick(); req = '0; res_vld = 4'b0011;
    tick(); res_vld = '0;
    checks++; if (cdb_tag_r !== 5'd10) begin errors++; $display("FAIL coll_tag got %0d exp 10", cdb_tag_r); end
    checks++; if (cdb_wdata_r !== 32'd0) begin errors++; $display("FAIL coll_data got %h exp 0", cdb_wdata_r); end
    checks++; if (err_r !== 1'b1) begin errors++; $display("FAIL coll_err got %b exp 1", err_r); end
    tick(); tick();
    checks++; if (err_r !== 1'b1) begin errors++; $display("FAIL coll_sticky got %b exp 1", err_r); end
  endtask

  task automatic test_illegal();
    do_reset();
    req = 4'b0100; set_lat(0, 0, 0, 0);
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL ill0_gnt got %b exp 0000", gnt); end
    tick(); req = '0;
    checks++; if (err_r !== 1'b1) begin errors++; $display("FAIL ill0_err got %b exp 1", err_r); end
    do_reset();
    checks++; if (err_r !== 1'b0) begin errors++; $display("FAIL ill_clr got %b exp 0", err_r); end
    req = 4'b0100; set_lat(0, 0, 9, 0);
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL ill9_gnt got %b exp 0000", gnt); end
    tick(); req = '0;
    checks++; if (err_r !== 1'b1) begin errors++; $display("FAIL ill9_err got %b exp 1", err_r); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0001; set_lat(5, 0, 0, 0);
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_g0 got %b exp 0001", gnt); end
    tick(); req = 4'b0010; set_lat(0, 6, 0, 0);
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL mid_g1 got %b exp 0010", gnt); end
    tick(); req = 4'b0100; set_lat(0, 0, 7, 0);
    #1;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL mid_g2 got %b exp 0100", gnt); end
    tick();
    checks++; if (sch_r !== 9'b001010100) begin errors++; $display("FAIL mid_sch got %b exp 001010100", sch_r); end
    rst = 1'b1; req = 4'b1111; set_lat(3, 3, 3, 3);
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mid_rst_gnt got %b exp 0000", gnt); end
    tick(); rst = 1'b0;
    checks++; if (sch_r !== 9'b0) begin errors++; $display("FAIL mid_sch_clr got %b exp 0", sch_r); end
    checks++; if (err_r !== 1'b0) begin errors++; $display("FAIL mid_err_clr got %b exp 0", err_r); end
    res_vld = 4'b0001;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_first got %b exp 0001", gnt); end
    tick(); req = '0; res_vld = '0;
    checks++; if (err_r !== 1'b1) begin errors++; $display("FAIL mid_unbooked got %b exp 1", err_r); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_slot_conflict();
    test_collision();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tomasulo_cdb_sched.md
TOMASULO_CDB_SCHED -- requirements
Module: tomasulo_cdb_sched

Interface
REQ-001 Parameter M, default 4: number of reservation-station requesters.
REQ-002 Parameter D, default 8: maximum execution latency in cycles (D >= 2).
REQ-003 Parameter W, default 32: CDB data width.
REQ-004 Parameter TW, default 5: CDB tag width.
REQ-005 Derived LW = $clog2(D+1): width of one latency field.
REQ-006 clk  in  1  clock; all state updates on posedge clk.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 req  in  M  per-requester CDB slot request; bit i from RS i.
REQ-009 lat  in  M*LW  per-requester latency; field i is lat[i*LW +: LW], legal range 1..D.
REQ-010 gnt  out  M  combinational grant; one-hot or zero.
REQ-011 sch_r  out  D+1  registered reservation vector; broadcast to all RSs.
REQ-012 res_vld  in  M  per-unit result valid.
REQ-013 res_tag  in  M*TW  per-unit result tag; field i is res_tag[i*TW +: TW].
REQ-014 res_wdata  in  M*W  per-unit result data; field i is res_wdata[i*W +: W].
REQ-015 cdb_vld_r  out  1  registered CDB valid.
REQ-016 cdb_tag_r  out  TW  registered CDB tag.
REQ-017 cdb_wdata_r  out  W  registered CDB data.
REQ-018 err_r  out  1  sticky protocol-error flag.

Function
REQ-019 sch_r[k] = 1 in cycle c: a result is booked for res_* in cycle c+k; bit D always reads 0.
REQ-020 Requester i is eligible when req[i] = 1, 1 <= L_i <= D, and sch_r[L_i] = 0.
REQ-021 At most one grant per cycle, round-robin among eligible requesters, starting at ptr+1 mod M.
REQ-022 ptr loads the granted index on a grant and holds otherwise.
REQ-023 gnt is forced to 0 while rst = 1.
REQ-024 Next state: sch_w[k] = sch_r[k+1] | (grant with L = k+1), for k in 0..D-1; sch_w[D] = 0.
REQ-025 Grant in cycle t with latency L: result due on res_* in cycle t+L; cdb_*_r valid in cycle t+L+1.
REQ-026 Grant latency, req to gnt, is 0 cycles (same cycle).
REQ-027 Illegal request (req[i] = 1 with L_i = 0 or L_i > D): never granted; err_r set next cycle.
REQ-028 cdb_vld_r <= |res_vld every cycle.
REQ-029 cdb_tag_r and cdb_wdata_r load the lowest-index valid unit's fields when |res_vld = 1 and hold otherwise.
REQ-030 err_r sets on $countones(res_vld) > 1 (collision).
REQ-031 err_r sets on (|res_vld) != sch_r[0] (unbooked or missing result).
REQ-032 On collision the lowest index still drives the CDB.
REQ-033 err_r clears only on rst.
REQ-034 Two requesters asking for the same slot in one cycle: only one is granted; the loser retries and sees the slot busy.

Reset
REQ-035 Reset values: sch_r = 0, ptr = M-1 (requester 0 wins first), cdb_vld_r = 0, cdb_tag_r = 0, cdb_wdata_r = 0, err_r = 0.
REQ-036 Reset mid-operation discards all bookings; results arriving in the first cycle after reset flag err_r.

Verification
REQ-037 After reset, req = 4'b0001, L0 = 3 in cycle 0 -> gnt = 4'b0001 in cycle 0; sch_r = 9'b000000100 in cycle 1; res_vld[0] in cycle 3 with tag 5, data 0xDEADBEEF -> cdb_vld_r = 1, tag 5, data 0xDEADBEEF in cycle 4; err_r = 0.
REQ-038 req = 4'b1111, all L = 2, held for 4 cycles -> grants 0,1,2,3 on consecutive cycles; sch_r[1] = 1 from cycle 1 onward; no errors.
REQ-039 Cycle 0: grant requester 1 with L = 4. Cycle 2: req[0] with L = 2 -> no grant (sch_r[2] = 1). Cycle 3: same request -> granted.
REQ-040 res_vld = 4'b0011 with sch_r[0] = 1 -> next-cycle cdb_tag_r = unit 0 tag; err_r = 1 and stays 1 until rst.
REQ-041 req[2] with L = 0, then L = 9 (D = 8) -> gnt = 0; err_r = 1.
REQ-042 Assert rst with three bookings outstanding -> sch_r = 0 next cycle; gnt = 0 during rst; after rst, requester 0 wins first.
